// File: rtl/r2r_adc_scan_scheduler_pkg.sv
// Shared types and constants for the R2R ADC scan scheduler.
//   sched_state_t : scheduler FSM state encoding
//   ADC_CODE_W    : width of the ADC conversion code
//   DEF_*         : default values for the top-level parameters
package r2r_sched_pkg;

  localparam int ADC_CODE_W        = 8;
  localparam int DEF_NUM_CH        = 4;
  localparam int DEF_SETTLE_CYCLES = 1000;
  localparam int DEF_DISCARD       = 1;
  localparam int DEF_AVG_LOG2      = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SWITCH,
    ST_SETTLE,
    ST_DISCARD,
    ST_ACCUM,
    ST_STORE,
    ST_NEXT
  } sched_state_t;

endpackage

// File: rtl/r2r_adc_scan_scheduler_rr_next_ch.sv
// Combinational round-robin channel finder.
//   mask     in  : channels eligible for the scan
//   cur      in  : current channel index
//   next_idx out : first set mask bit strictly after cur, wrapping
//   wrapped  out : the search passed the top channel (includes landing on cur)
//   none     out : mask is empty
module r2r_rr_next_ch
  import r2r_sched_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH
) (
  input  logic [NUM_CH-1:0]         mask,
  input  logic [$clog2(NUM_CH)-1:0] cur,
  output logic [$clog2(NUM_CH)-1:0] next_idx,
  output logic                      wrapped,
  output logic                      none
);

  localparam int IW = $clog2(NUM_CH);

  logic              found_after;
  logic [NUM_CH-1:0] sh;

  // Descending loops so the lowest qualifying index is the last one written.
  always_comb begin
    next_idx    = '0;
    found_after = 1'b0;
    sh          = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      sh = mask >> i;
      if (sh[0] && (i > int'(cur))) begin
        next_idx    = i[IW-1:0];
        found_after = 1'b1;
      end
    end
    if (!found_after) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        sh = mask >> i;
        if (sh[0]) next_idx = i[IW-1:0];
      end
    end
    none    = (mask == '0);
    wrapped = !found_after && !none;
  end

endmodule

// File: rtl/r2r_adc_scan_scheduler.sv
// Round-robin scan scheduler for the shared R2R ADC.
// Selects each enabled mux channel in turn, waits out settling and stale
// conversions, averages 2^AVG_LOG2 codes and stores one result per channel.
//   clk, reset (sync, active-low)   : clock and reset
//   enable, ch_mask, sar_mode_req   : scan control
//   adc_ready, adc_code             : conversion stream from the ADC
//   mux_sel, sar_mode               : drives to the analog mux / ADC
//   busy                            : FSM not idle
//   result_valid/ch/data            : one-cycle result strobe
//   scan_done                       : end of a full pass
//   rd_ch -> rd_data, rd_fresh      : combinational result bank read
//
// state   | meaning
// IDLE    | not scanning
// SWITCH  | load mux_sel/sar_mode, clear accumulator
// SETTLE  | wait SETTLE_CYCLES after a switch
// DISCARD | drop DISCARD stale conversions
// ACCUM   | sum 2^AVG_LOG2 conversions
// STORE   | write the bank entry, result strobe out
// NEXT    | pick the next channel or go idle
module r2r_adc_scan_scheduler
  import r2r_sched_pkg::*;
#(
  parameter int NUM_CH        = DEF_NUM_CH,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int DISCARD       = DEF_DISCARD,
  parameter int AVG_LOG2      = DEF_AVG_LOG2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NUM_CH-1:0]         ch_mask,
  input  logic                      sar_mode_req,
  input  logic                      adc_ready,
  input  logic [ADC_CODE_W-1:0]     adc_code,
  input  logic [$clog2(NUM_CH)-1:0] rd_ch,
  output logic [$clog2(NUM_CH)-1:0] mux_sel,
  output logic                      sar_mode,
  output logic                      busy,
  output logic                      result_valid,
  output logic [$clog2(NUM_CH)-1:0] result_ch,
  output logic [ADC_CODE_W-1:0]     result_data,
  output logic                      scan_done,
  output logic [ADC_CODE_W-1:0]     rd_data,
  output logic                      rd_fresh
);

  localparam int IW    = $clog2(NUM_CH);
  localparam int DEPTH = 1 << IW;
  localparam int ACC_W = ADC_CODE_W + AVG_LOG2;
  localparam int SW    = $clog2(SETTLE_CYCLES + 1);
  localparam int CW    = AVG_LOG2 + 1;

  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [3:0]    DISC_LOAD   = 4'(DISCARD - 1);
  localparam logic [CW-1:0] SAMP_LOAD   = CW'((1 << AVG_LOG2) - 1);

  sched_state_t state, state_nxt;

  logic [IW-1:0]    tgt;
  logic [SW-1:0]    settle_cnt;
  logic [3:0]       disc_cnt;
  logic [CW-1:0]    samp_cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;

  // Bank padded to a power of two so any rd_ch is a legal index; the
  // padding entries are never written and read back as zero.
  logic [DEPTH-1:0][ADC_CODE_W-1:0] bank;
  logic [DEPTH-1:0]                 fresh;

  logic [IW-1:0] rr_cur;
  logic [IW-1:0] nxt_idx;
  logic          nxt_wrap;
  logic          mask_none;

  // From IDLE the target may be mux_sel itself, so search from one below it.
  assign rr_cur = (state != ST_IDLE) ? mux_sel :
                  (mux_sel == '0)    ? IW'(NUM_CH - 1) : mux_sel - IW'(1);

  r2r_rr_next_ch #(.NUM_CH(NUM_CH)) u_rr (
    .mask     (ch_mask),
    .cur      (rr_cur),
    .next_idx (nxt_idx),
    .wrapped  (nxt_wrap),
    .none     (mask_none)
  );

  assign acc_sum = acc + ACC_W'(adc_code);
  assign rd_data  = bank[rd_ch];
  assign rd_fresh = fresh[rd_ch];

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != ST_IDLE);
    scan_done = 1'b0;
    case (state)
      ST_IDLE:    if (enable && !mask_none) state_nxt = ST_SWITCH;
      ST_SWITCH:  state_nxt = ST_SETTLE;
      ST_SETTLE:  if (settle_cnt == '0) state_nxt = (DISCARD == 0) ? ST_ACCUM : ST_DISCARD;
      ST_DISCARD: if (adc_ready && disc_cnt == '0) state_nxt = ST_ACCUM;
      ST_ACCUM:   if (adc_ready && samp_cnt == '0) state_nxt = ST_STORE;
      ST_STORE:   state_nxt = ST_NEXT;
      ST_NEXT: begin
        if (!enable || mask_none) begin
          state_nxt = ST_IDLE;
        end else begin
          // Landing back on mux_sel always reports wrapped.
          scan_done = nxt_wrap;
          if (nxt_idx == mux_sel && sar_mode_req == sar_mode) state_nxt = ST_ACCUM;
          else                                                state_nxt = ST_SWITCH;
        end
      end
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mux_sel      <= '0;
      sar_mode     <= 1'b0;
      tgt          <= '0;
      settle_cnt   <= '0;
      disc_cnt     <= '0;
      samp_cnt     <= '0;
      acc          <= '0;
      result_valid <= 1'b0;
      result_ch    <= '0;
      result_data  <= '0;
      bank         <= '0;
      fresh        <= '0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        ST_IDLE: tgt <= nxt_idx;
        ST_SWITCH: begin
          mux_sel    <= tgt;
          sar_mode   <= sar_mode_req;
          acc        <= '0;
          settle_cnt <= SETTLE_LOAD;
          disc_cnt   <= DISC_LOAD;
          samp_cnt   <= SAMP_LOAD;
        end
        ST_SETTLE: if (settle_cnt != '0) settle_cnt <= settle_cnt - SW'(1);
        ST_DISCARD: if (adc_ready) disc_cnt <= disc_cnt - 4'd1;
        ST_ACCUM: begin
          if (adc_ready) begin
            acc      <= acc_sum;
            samp_cnt <= samp_cnt - CW'(1);
            // The average is formed on the final sample so the strobe and
            // data are already registered during STORE.
            if (samp_cnt == '0) begin
              result_valid <= 1'b1;
              result_ch    <= mux_sel;
              result_data  <= acc_sum[ACC_W-1 -: ADC_CODE_W];
            end
          end
        end
        ST_STORE: begin
          bank[mux_sel]  <= result_data;
          fresh[mux_sel] <= 1'b1;
        end
        ST_NEXT: begin
          tgt      <= nxt_idx;
          acc      <= '0;
          samp_cnt <= SAMP_LOAD;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_r2r_adc_scan_scheduler.sv
module tb_r2r_adc_scan_scheduler;
  import r2r_sched_pkg::*;

  localparam int NUM_CH = 4;
  localparam int SETTLE = 10;
  localparam int DISC   = 1;
  localparam int AVG    = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] ch_mask = '0;
  logic       sar_mode_req = 1'b0;
  logic       adc_ready = 1'b0;
  logic [7:0] adc_code = '0;
  logic [1:0] rd_ch = '0;
  logic [1:0] mux_sel;
  logic       sar_mode;
  logic       busy;
  logic       result_valid;
  logic [1:0] result_ch;
  logic [7:0] result_data;
  logic       scan_done;
  logic [7:0] rd_data;
  logic       rd_fresh;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [1:0] m_mux;
  logic       m_mode;
  logic [7:0] bank_m [4];
  logic [3:0] fresh_m;
  bit         nxt_sw;

  always #5 clk = ~clk;

  r2r_adc_scan_scheduler #(
    .NUM_CH(NUM_CH), .SETTLE_CYCLES(SETTLE), .DISCARD(DISC), .AVG_LOG2(AVG)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .ch_mask(ch_mask),
    .sar_mode_req(sar_mode_req), .adc_ready(adc_ready), .adc_code(adc_code),
    .rd_ch(rd_ch), .mux_sel(mux_sel), .sar_mode(sar_mode), .busy(busy),
    .result_valid(result_valid), .result_ch(result_ch), .result_data(result_data),
    .scan_done(scan_done), .rd_data(rd_data), .rd_fresh(rd_fresh)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Spec-level round-robin search with modulo arithmetic.
  function automatic void rr(input logic [3:0] mask, input int cur, input bit incl,
                             output int nxt, output bit wrap);
    nxt  = cur;
    wrap = 1'b0;
    for (int k = (incl ? 0 : 1); k <= (incl ? NUM_CH - 1 : NUM_CH); k++) begin
      if (mask[2'((cur + k) % NUM_CH)]) begin
        nxt  = (cur + k) % NUM_CH;
        wrap = (cur + k >= NUM_CH);
        return;
      end
    end
  endfunction

  task automatic reset_model();
    m_mux   = '0;
    m_mode  = 1'b0;
    fresh_m = '0;
    for (int i = 0; i < 4; i++) bank_m[i] = '0;
  endtask

  task automatic check_reset_values();
    chk("rst_mux_sel", mux_sel, 0);
    chk("rst_sar_mode", sar_mode, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_result_ch", result_ch, 0);
    chk("rst_result_data", result_data, 0);
    chk("rst_scan_done", scan_done, 0);
    for (int r = 0; r < 4; r++) begin
      rd_ch = 2'(r);
      #1;
      chk("rst_rd_data", rd_data, 0);
      chk("rst_rd_fresh", rd_fresh, 0);
    end
  endtask

  task automatic start_from_idle();
    int  n;
    bit  w;
    rr(ch_mask, int'(m_mux), 1'b1, n, w);
    m_mux  = 2'(n);
    m_mode = sar_mode_req;
    tick();
    nxt_sw = 1'b1;
  endtask

  // One channel visit, entered #1 after the edge into SWITCH (sw=1) or ACCUM.
  task automatic visit(input bit sw, input bit use_codes, input logic [31:0] codes,
                       input bit tog_mode, input bit drop_en, input logic [3:0] nmask);
    logic [9:0] sum;
    logic [7:0] code;
    logic [7:0] expv;
    int         n;
    bit         w;
    rd_ch = m_mux;
    if (sw) begin
      chk("switch_busy", busy, 1);
      adc_ready = 1'($urandom_range(0, 1));
      adc_code  = 8'($urandom);
      tick();
      adc_ready = 1'b0;
      chk("mux_sel", mux_sel, m_mux);
      chk("sar_mode", sar_mode, m_mode);
      for (int i = 0; i < SETTLE; i++) begin
        adc_ready = ($urandom_range(0, 2) == 0);
        adc_code  = 8'($urandom);
        if (drop_en && i == 2) enable = 1'b0;
        tick();
      end
      adc_ready = 1'b0;
      for (int d = 0; d < DISC; d++) begin
        repeat ($urandom_range(0, 3)) tick();
        adc_ready = 1'b1;
        adc_code  = 8'($urandom);
        tick();
        adc_ready = 1'b0;
      end
    end
    sum = '0;
    for (int k = 0; k < (1 << AVG); k++) begin
      code = use_codes ? codes[8*k +: 8] : 8'($urandom);
      if (tog_mode && k == 1) sar_mode_req = ~sar_mode_req;
      repeat ($urandom_range(0, 3)) tick();
      adc_ready = 1'b1;
      adc_code  = code;
      tick();
      adc_ready = 1'b0;
      sum += 10'(code);
    end
    expv = sum[9:2];
    chk("result_valid", result_valid, 1);
    chk("result_ch", result_ch, m_mux);
    chk("result_data", result_data, expv);
    chk("store_mux", mux_sel, m_mux);
    chk("store_mode", sar_mode, m_mode);
    chk("rd_old", rd_data, bank_m[m_mux]);
    adc_ready = 1'($urandom_range(0, 1));
    adc_code  = 8'($urandom);
    ch_mask   = nmask;
    tick();
    adc_ready = 1'b0;
    bank_m[m_mux]  = expv;
    fresh_m[m_mux] = 1'b1;
    chk("valid_pulse", result_valid, 0);
    chk("rd_new", rd_data, expv);
    chk("rd_fresh", rd_fresh, 1);
    if (!enable || ch_mask == '0) begin
      nxt_sw = 1'b0;
      tick();
      chk("idle_busy", busy, 0);
      chk("idle_mux_hold", mux_sel, m_mux);
    end else begin
      rr(ch_mask, int'(m_mux), 1'b0, n, w);
      chk("scan_done", scan_done, 32'(w || n == int'(m_mux)));
      nxt_sw = !(2'(n) == m_mux && sar_mode_req == m_mode);
      m_mux  = 2'(n);
      if (nxt_sw) m_mode = sar_mode_req;
      adc_ready = 1'($urandom_range(0, 1));
      adc_code  = 8'($urandom);
      tick();
      adc_ready = 1'b0;
      chk("next_busy", busy, 1);
    end
  endtask

  initial begin
    logic [3:0] nm;
    reset_model();
    nxt_sw = 1'b0;
    reset = 1'b0;
    repeat (3) tick();
    check_reset_values();
    reset = 1'b1;
    tick();
    chk("idle_no_enable", busy, 0);

    // Round-robin with skipped channels, disabled during the last settle.
    ch_mask = 4'b1010;
    sar_mode_req = 1'b0;
    enable = 1'b1;
    start_from_idle();
    for (int v = 0; v < 4; v++) visit(nxt_sw, 1'b0, '0, 1'b0, (v == 3), 4'b1010);
    for (int r = 0; r < 4; r++) begin
      rd_ch = 2'(r);
      #1;
      chk("rr_fresh", rd_fresh, fresh_m[r]);
      chk("rr_data", rd_data, bank_m[r]);
    end

    // Single channel: static codes, truncation, back-to-back ACCUM, mode change.
    ch_mask = 4'b0001;
    sar_mode_req = 1'b0;
    enable = 1'b1;
    start_from_idle();
    visit(nxt_sw, 1'b1, 32'h40404040, 1'b0, 1'b0, 4'b0001);
    visit(nxt_sw, 1'b1, 32'hFEFFFFFF, 1'b0, 1'b0, 4'b0001);
    visit(nxt_sw, 1'b1, 32'h02020201, 1'b0, 1'b0, 4'b0001);
    visit(nxt_sw, 1'b0, '0, 1'b1, 1'b0, 4'b0001);
    visit(nxt_sw, 1'b0, '0, 1'b0, 1'b0, 4'b0001);

    // Reset in the middle of an accumulation.
    adc_ready = 1'b1;
    adc_code = 8'h33;
    tick();
    tick();
    adc_ready = 1'b0;
    reset = 1'b0;
    enable = 1'b0;
    tick();
    reset_model();
    check_reset_values();
    reset = 1'b1;
    tick();

    // Randomized masks, modes and codes; enable drops on the final channel.
    enable = 1'b1;
    ch_mask = 4'($urandom_range(1, 15));
    sar_mode_req = 1'($urandom_range(0, 1));
    start_from_idle();
    for (int v = 0; v < 12; v++) begin
      nm = ($urandom_range(0, 1) == 1) ? ch_mask : 4'($urandom_range(1, 15));
      if (v == 11) enable = 1'b0;
      visit(nxt_sw, 1'b0, '0, ($urandom_range(0, 3) == 0), 1'b0, nm);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
